// File: rtl/clock_pkg.sv
// clock_pkg: shared constants, state encodings and ASCII helper for the clock's UART paths
package clock_pkg;
    localparam int         CLKS_PER_BIT_DEFAULT = 4;
    localparam logic [7:0] PAD_DEFAULT          = 8'h3F;
    localparam logic [7:0] ASCII_ZERO           = 8'h30;
    localparam logic [7:0] ASCII_COLON          = 8'h3A;
    localparam logic [7:0] ASCII_CR             = 8'h0D;
    localparam logic [7:0] ASCII_LF             = 8'h0A;
    localparam int         LINE_LEN             = 7;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD, SEQ_WAIT, SEQ_FINISH} seq_state_t;
    typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_state_t;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d, input logic [7:0] pad);
        return (d <= 4'd9) ? ASCII_ZERO + {4'h0, d} : pad;
    endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer with ready/valid hand-off and back-to-back frames
module uart_tx_byte
    import clock_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       Tx,
    output logic       ready
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    ser_state_t    state, state_n;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    sh, sh_n;
    logic          wrap, load, tx_n;

    assign wrap  = baud == BW'(CLKS_PER_BIT - 1);
    assign ready = state == SER_IDLE || (state == SER_STOP && wrap);
    assign load  = ready && valid;

    // state register
    always_ff @(posedge clk)
        state <= !reset_ ? SER_IDLE : state_n;

    // next state: a new byte at stop end goes straight to another start bit
    always_comb begin
        state_n = state;
        case (state)
            SER_IDLE:  state_n = valid ? SER_START : SER_IDLE;
            SER_START: state_n = wrap ? SER_DATA : SER_START;
            SER_DATA:  state_n = (wrap && bit_idx == 3'd7) ? SER_STOP : SER_DATA;
            SER_STOP:  state_n = wrap ? (valid ? SER_START : SER_IDLE) : SER_STOP;
            default:   state_n = SER_IDLE;
        endcase
    end

    // output decode: next line level computed from the next state so Tx can be a flop
    always_comb begin
        sh_n = load ? data : (state == SER_DATA && wrap) ? sh >> 1 : sh;
        tx_n = (state_n == SER_START) ? 1'b0 : (state_n == SER_DATA) ? sh_n[0] : 1'b1;
    end

    // baud/bit counters, shift register and registered line
    always_ff @(posedge clk) begin
        if (!reset_) begin
            baud    <= '0;
            bit_idx <= '0;
            sh      <= '0;
            Tx      <= 1'b1;
        end else begin
            baud    <= (load || wrap || state == SER_IDLE) ? '0 : baud + BW'(1);
            bit_idx <= load ? 3'd0 : (state == SER_DATA && wrap) ? bit_idx + 3'd1 : bit_idx;
            sh      <= sh_n;
            Tx      <= tx_n;
        end
    end
endmodule

// File: rtl/uart_time_tx.sv
// uart_time_tx: sends the latched time as the ASCII line "HH:MM\r\n" over UART 8N1
module uart_time_tx
    import clock_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter logic [7:0] PAD_CHAR     = PAD_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       send,
    input  logic [3:0] hour_tens,
    input  logic [3:0] hour_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_units,
    output logic       Tx,
    output logic       busy,
    output logic       done
);
    seq_state_t state, state_n;
    logic [3:0] dig [4];
    logic [2:0] idx;
    logic [7:0] cur_char, ser_data;
    logic       ser_valid, ser_ready, accept;

    assign accept = (state == SEQ_IDLE || state == SEQ_FINISH) && send;

    // state register
    always_ff @(posedge clk)
        state <= !reset_ ? SEQ_IDLE : state_n;

    // next state: char 0 is handed off on the accept edge, the rest queue up behind the serializer
    always_comb begin
        state_n = state;
        case (state)
            SEQ_IDLE, SEQ_FINISH: state_n = send ? SEQ_WAIT : SEQ_IDLE;
            SEQ_LOAD: state_n = ser_ready ? SEQ_WAIT : SEQ_LOAD;
            SEQ_WAIT: state_n = (idx != 3'(LINE_LEN - 1)) ? SEQ_LOAD :
                                ser_ready ? SEQ_FINISH : SEQ_WAIT;
            default:  state_n = SEQ_IDLE;
        endcase
    end

    // character at the current line index
    always_comb begin
        cur_char = ASCII_LF;
        case (idx)
            3'd0:    cur_char = digit_ascii(dig[0], PAD_CHAR);
            3'd1:    cur_char = digit_ascii(dig[1], PAD_CHAR);
            3'd2:    cur_char = ASCII_COLON;
            3'd3:    cur_char = digit_ascii(dig[2], PAD_CHAR);
            3'd4:    cur_char = digit_ascii(dig[3], PAD_CHAR);
            3'd5:    cur_char = ASCII_CR;
            default: cur_char = ASCII_LF;
        endcase
    end

    // outputs: on accept the first digit goes straight from the inputs so the start bit has no extra latency
    always_comb begin
        ser_valid = accept || state == SEQ_LOAD;
        ser_data  = accept ? digit_ascii(hour_tens, PAD_CHAR) : cur_char;
        busy      = state == SEQ_LOAD || state == SEQ_WAIT;
        done      = state == SEQ_FINISH;
    end

    // digit latch and character index
    always_ff @(posedge clk) begin
        if (!reset_) begin
            dig <= '{4'h0, 4'h0, 4'h0, 4'h0};
            idx <= '0;
        end else if (accept) begin
            dig <= '{hour_tens, hour_units, min_tens, min_units};
            idx <= '0;
        end else if (state == SEQ_WAIT && state_n == SEQ_LOAD) begin
            idx <= idx + 3'd1;
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clk    (clk),
        .reset_ (reset_),
        .data   (ser_data),
        .valid  (ser_valid),
        .Tx     (Tx),
        .ready  (ser_ready)
    );
endmodule

// File: tb/tb_uart_time_tx.sv
// tb_uart_time_tx: timeline model, UART decoder and directed line tests for uart_time_tx
module tb_uart_time_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset_, send;
    logic [3:0] hour_tens, hour_units, min_tens, min_units;
    logic Tx, busy, done;

    int passed = 0;
    int total  = 0;

    uart_time_tx #(.CLKS_PER_BIT(CPB), .PAD_CHAR(8'h3F)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .send       (send),
        .hour_tens  (hour_tens),
        .hour_units (hour_units),
        .min_tens   (min_tens),
        .min_units  (min_units),
        .Tx         (Tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] asc(input logic [3:0] d);
        return (d <= 4'd9) ? 8'h30 + {4'h0, d} : 8'h3F;
    endfunction

    // Model: an accepted request turns into a 70-bit line waveform, each bit held CPB cycles
    int   left = 0;
    int   pos  = 0;
    logic etx = 1'b1, ebusy = 1'b0, edone = 1'b0;
    bit   mvalid = 1'b0;
    logic mbits [0:69];
    logic [7:0] mch [7];

    always @(posedge clk) begin
        if (!reset_) begin
            left = 0; etx = 1'b1; ebusy = 1'b0; edone = 1'b0; mvalid = 1'b1;
        end else if (left == 0 && send) begin
            mch = '{asc(hour_tens), asc(hour_units), 8'h3A, asc(min_tens), asc(min_units), 8'h0D, 8'h0A};
            for (int c = 0; c < 7; c++) begin
                mbits[10*c] = 1'b0;
                for (int j = 0; j < 8; j++) mbits[10*c+1+j] = mch[c][j];
                mbits[10*c+9] = 1'b1;
            end
            left = 70 * CPB; pos = 0; etx = mbits[0]; ebusy = 1'b1; edone = 1'b0;
        end else if (left > 0) begin
            left--; pos++;
            ebusy = left > 0;
            edone = left == 0;
            etx   = (left > 0) ? mbits[pos / CPB] : 1'b1;
        end else begin
            etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
        end
    end

    always @(negedge clk)
        if (mvalid) chk("line", {29'b0, Tx, busy, done}, {29'b0, etx, ebusy, edone});

    // UART decoder: samples mid-bit and collects received bytes
    logic [7:0] dq [$];
    bit   infr = 1'b0;
    int   dc = 0;
    int   ferr = 0;
    logic [7:0] dsh = '0;

    always @(negedge clk) begin
        if (!reset_) infr = 1'b0;
        else if (!infr) begin
            if (Tx === 1'b0) begin infr = 1'b1; dc = 0; end
        end else begin
            dc++;
            if (dc % CPB == CPB / 2 && dc / CPB >= 1 && dc / CPB <= 8) dsh = {Tx, dsh[7:1]};
            if (dc == 9 * CPB + CPB / 2) begin
                if (Tx !== 1'b1) ferr++;
                dq.push_back(dsh);
                infr = 1'b0;
            end
        end
    end

    logic hist [0:511];

    task automatic run(input bit do_send, input logic [15:0] dg, input int mode, input int at,
                       input logic [15:0] idg, input bit chain, input logic [15:0] cdg,
                       output int done_at, output int busy_n);
        int k;
        done_at = -1;
        busy_n  = 0;
        if (do_send) begin
            @(negedge clk);
            {hour_tens, hour_units, min_tens, min_units} = dg;
            send = 1'b1;
        end
        @(negedge clk);
        send = 1'b0;
        k = 1;
        forever begin
            hist[k] = Tx;
            if (busy) busy_n++;
            if (done) begin
                done_at = k;
                if (chain) begin
                    {hour_tens, hour_units, min_tens, min_units} = cdg;
                    send = 1'b1;
                end
                break;
            end
            if (mode == 1 && k == at) begin
                {hour_tens, hour_units, min_tens, min_units} = idg;
                send = 1'b1;
            end
            if (mode == 1 && k == at + 1) send = 1'b0;
            if (mode == 2 && k == at) reset_ = 1'b0;
            if (mode == 2 && k == at + 3) begin
                reset_ = 1'b1;
                break;
            end
            if (k >= 450) begin
                chk("timeout", 32'(k), 32'(0));
                break;
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic chk_q(input string nm, input logic [55:0] e, input int n);
        chk({nm, "_len"}, 32'(dq.size()), 32'(n));
        for (int i = 0; i < n && i < dq.size(); i++) chk(nm, 32'(dq[i]), 32'(e[55-8*i -: 8]));
        dq.delete();
    endtask

    int da, bn;

    initial begin
        reset_ = 1'b0; send = 1'b1;
        {hour_tens, hour_units, min_tens, min_units} = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out", {29'b0, Tx, busy, done}, 32'b100);
        end
        reset_ = 1'b1; send = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_idle", {29'b0, Tx, busy}, 32'b10);
        end
        dq.delete();

        run(1'b1, 16'h1234, 0, 0, 16'h0, 1'b0, 16'h0, da, bn);
        chk("t2_done_at", 32'(da), 32'd281);
        chk("t2_busy_cycles", 32'(bn), 32'd280);
        chk("t2_first_bits", {24'b0, hist[1], hist[2], hist[3], hist[4], hist[5], hist[6], hist[7], hist[8]}, 32'h0F);
        chk("t2_bit1", {31'b0, hist[9]}, 32'd0);
        chk_q("t2_chars", 56'h31_32_3A_33_34_0D_0A, 7);

        run(1'b1, 16'h2359, 1, 40, 16'h0000, 1'b0, 16'h0, da, bn);
        chk("t3_done_at", 32'(da), 32'd281);
        repeat (300) @(negedge clk);
        chk("t3_busy_after", {31'b0, busy}, 32'd0);
        chk_q("t3_chars", 56'h32_33_3A_35_39_0D_0A, 7);

        run(1'b1, 16'h1234, 0, 0, 16'h0, 1'b1, 16'h0905, da, bn);
        chk("t4a_done_at", 32'(da), 32'd281);
        chk("t4_idle_tx", {31'b0, hist[281]}, 32'd1);
        chk_q("t4a_chars", 56'h31_32_3A_33_34_0D_0A, 7);
        run(1'b0, 16'h0, 0, 0, 16'h0, 1'b0, 16'h0, da, bn);
        chk("t4_start_after_gap", {31'b0, hist[1]}, 32'd0);
        chk("t4b_done_at", 32'(da), 32'd281);
        chk_q("t4b_chars", 56'h30_39_3A_30_35_0D_0A, 7);

        run(1'b1, 16'hF0A7, 0, 0, 16'h0, 1'b0, 16'h0, da, bn);
        chk("t5_done_at", 32'(da), 32'd281);
        chk_q("t5_chars", 56'h3F_30_3A_3F_37_0D_0A, 7);

        run(1'b1, 16'h1234, 2, 100, 16'h0, 1'b0, 16'h0, da, bn);
        chk("t6_no_done", da, -1);
        repeat (20) begin
            @(negedge clk);
            chk("t6_quiet", {29'b0, Tx, busy, done}, 32'b100);
        end
        chk_q("t6_partial", {8'h31, 8'h32, 40'h0}, 2);
        run(1'b1, 16'h1234, 0, 0, 16'h0, 1'b0, 16'h0, da, bn);
        chk("t6_done_at", 32'(da), 32'd281);
        chk_q("t6_chars", 56'h31_32_3A_33_34_0D_0A, 7);

        repeat (10) @(negedge clk);
        chk("framing", 32'(ferr), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
